// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI stream sequencer: widths, matcher latencies,
// FSM state encoding and the flow-key to stream-id hash.
package dpi_pkg;

  localparam int KEY_W    = 32;
  localparam int SID_W    = 6;
  localparam int LOAD_GAP = 2;  // load_state -> first char_in_vld, must be >= 2
  localparam int EOP_GAP  = 2;  // last char_in_vld -> eop, must be >= 1

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    GAP,
    STREAM,
    DRAIN,
    EOP
  } dpi_state_t;

  // Folds the 32-bit key into six 6-bit slices; the top slice only has two bits.
  function automatic logic [SID_W-1:0] dpi_sid_hash(input logic [KEY_W-1:0] key);
    return key[5:0] ^ key[11:6] ^ key[17:12] ^ key[23:18] ^ key[29:24] ^ {4'b0, key[31:30]};
  endfunction

endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Ingress byte stream: valid/ready handshake with packet delimiters and per-packet flow key.
interface dpi_stream_sequencer_if;
  import dpi_pkg::*;

  logic             valid;
  logic             ready;
  logic [7:0]       data;
  logic             sop;
  logic             eop;
  logic [KEY_W-1:0] key;

  modport master (output valid, data, sop, eop, key, input ready);
  modport slave  (input valid, data, sop, eop, key, output ready);

endinterface

// File: rtl/dpi_flow_table.sv
// Direct-mapped flow table: 2**SID_W tags plus valid bits, one-cycle registered read,
// synchronous write; valid bits cleared by reset, tag storage left uninitialised.
module dpi_flow_table
  import dpi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [SID_W-1:0] rd_addr,
  input  logic [KEY_W-1:0] cmp_key,
  input  logic             wr_en,
  input  logic [SID_W-1:0] wr_addr,
  input  logic [KEY_W-1:0] wr_tag,
  output logic             hit,
  output logic             occupied
);

  logic [KEY_W-1:0]      tag_mem [2**SID_W];
  logic [2**SID_W-1:0]   vld;
  logic [KEY_W-1:0]      rd_tag;
  logic                  rd_vld;

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_addr] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_tag <= '0;
      rd_vld <= 1'b0;
    end else begin
      if (wr_en) vld[wr_addr] <= 1'b1;
      if (rd_en) begin
        rd_tag <= tag_mem[rd_addr];
        rd_vld <= vld[rd_addr];
      end
    end
  end

  assign occupied = rd_vld;
  assign hit      = rd_vld && (rd_tag == cmp_key);

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Packet sequencer in front of the per-stream regex matcher bank.
// Optional STREAM_STATS_EN builds the packet and eviction counters; otherwise they read 0.
//
// state  | meaning
// IDLE   | wait for sop (peeked, not consumed); stray non-sop bytes are dropped
// LOOKUP | flow table read result available; write key into table
// LOAD   | load_state pulse, stream_id/enable/new_stream_id presented
// GAP    | matcher state restore; ingress opens on the last GAP cycle
// STREAM | forward accepted bytes to char_in
// DRAIN  | wait for matcher pipelines to flush
// EOP    | eop pulse
module dpi_stream_sequencer
  import dpi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  dpi_stream_sequencer_if.slave  in_if,
  input  logic                   cfg_we,
  input  logic [SID_W-1:0]       cfg_addr,
  input  logic                   cfg_wdata,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [SID_W-1:0]       stream_id,
  output logic                   enable,
  output logic                   eop,
  output logic [31:0]            pkt_count,
  output logic [31:0]            coll_count
);

  localparam logic [3:0] GAP_INIT   = 4'(LOAD_GAP - 2);
  localparam logic [3:0] DRAIN_INIT = 4'(EOP_GAP - 1);

  dpi_state_t        state, state_nxt;
  logic [KEY_W-1:0]  key_q;
  logic [SID_W-1:0]  sid_q;
  logic [3:0]        tmr;
  logic              tmr_tc;
  logic [2**SID_W-1:0] en_map;
  logic              hit, occupied;
  logic              sop_peek, streaming, beat;

  dpi_flow_table u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (sop_peek),
    .rd_addr  (dpi_sid_hash(in_if.key)),
    .cmp_key  (key_q),
    .wr_en    (state == LOOKUP),
    .wr_addr  (sid_q),
    .wr_tag   (key_q),
    .hit      (hit),
    .occupied (occupied)
  );

  always_comb begin
    tmr_tc      = (tmr == 4'd0);
    sop_peek    = (state == IDLE) && in_if.valid && in_if.sop;
    // Ingress opens one cycle early so the first char lands exactly LOAD_GAP after load_state.
    streaming   = (state == STREAM) || ((state == GAP) && tmr_tc);
    in_if.ready = streaming || ((state == IDLE) && in_if.valid && !in_if.sop);
    beat        = streaming && in_if.valid;
    load_state  = (state == LOAD);
    eop         = (state == EOP);
    state_nxt   = state;
    case (state)
      IDLE:    if (sop_peek) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = LOAD;
      LOAD:    state_nxt = GAP;
      GAP:     if (tmr_tc) state_nxt = (beat && in_if.eop) ? DRAIN : STREAM;
      STREAM:  if (beat && in_if.eop) state_nxt = DRAIN;
      DRAIN:   if (tmr_tc) state_nxt = EOP;
      EOP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      key_q         <= '0;
      sid_q         <= '0;
      tmr           <= '0;
      en_map        <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      new_stream_id <= 1'b0;
      stream_id     <= '0;
      enable        <= 1'b0;
    end else begin
      state       <= state_nxt;
      char_in_vld <= beat;
      if (beat) char_in <= in_if.data;
      if (cfg_we) en_map[cfg_addr] <= cfg_wdata;
      if (sop_peek) begin
        key_q <= in_if.key;
        sid_q <= dpi_sid_hash(in_if.key);
      end
      // Enable is sampled before any cfg write issued alongside load_state can land.
      if (state == LOOKUP) begin
        new_stream_id <= !hit;
        stream_id     <= sid_q;
        enable        <= en_map[sid_q];
      end
      if (state == LOAD)          tmr <= GAP_INIT;
      else if (beat && in_if.eop) tmr <= DRAIN_INIT;
      else if (!tmr_tc)           tmr <= tmr - 4'd1;
    end
  end

`ifdef STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      coll_count <= '0;
    end else begin
      if (state == EOP) pkt_count <= pkt_count + 32'd1;
      if ((state == LOOKUP) && occupied && !hit) coll_count <= coll_count + 32'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = occupied;
  assign pkt_count    = '0;
  assign coll_count   = '0;
`endif

endmodule
